// File: rtl/dcache_2way.sv
// rtl/dcache_2way.sv - 2-way set-associative write-back, write-allocate data cache
// Flop-array tag/data store with zero-stall hits; one miss in flight (optional writeback, then fill).
module dcache_2way #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = OFF_W - 2;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL_REQ, S_FILL} state_t;

    logic [TAG_W-1:0]  tag_mem   [2][SETS];
    logic [LINE_W-1:0] data_mem  [2][SETS];
    logic [SETS-1:0]   valid_mem [2];
    logic [SETS-1:0]   dirty_mem [2];
    logic [SETS-1:0]   lru_mem;

    state_t            state_q, state_d;
    logic              victim_q, victim_d;
    logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0]  miss_tag_q, miss_tag_d;
    logic              miss_pend_q, miss_pend_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]  p1_tag;
    logic [IDX_W-1:0]  p1_idx;
    logic [WSEL_W-1:0] p1_word;
    logic              req, hit0, hit1, hit, hit_way, wr_hit, victim_way, fill_we;
    logic [LINE_W-1:0] hit_line;
    logic              unused_addr_lsb;

    assign p1_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign p1_idx          = p1_addr_i[OFF_W +: IDX_W];
    assign p1_word         = p1_addr_i[2 +: WSEL_W];
    assign unused_addr_lsb = ^p1_addr_i[1:0];

    always_comb begin
        req        = p1_MemRead_i | p1_MemWrite_i;
        hit0       = valid_mem[0][p1_idx] && (tag_mem[0][p1_idx] == p1_tag);
        hit1       = valid_mem[1][p1_idx] && (tag_mem[1][p1_idx] == p1_tag);
        hit        = hit0 | hit1;
        hit_way    = hit1;
        wr_hit     = p1_MemWrite_i & hit;
        hit_line   = hit1 ? data_mem[1][p1_idx] : data_mem[0][p1_idx];
        p1_stall_o = req & ~hit;
        p1_data_o  = (p1_MemRead_i && hit) ? hit_line[{p1_word, 5'b0} +: 32] : 32'h0;
        // Invalid ways are filled before any valid line is displaced.
        if (!valid_mem[0][p1_idx])      victim_way = 1'b0;
        else if (!valid_mem[1][p1_idx]) victim_way = 1'b1;
        else                            victim_way = lru_mem[p1_idx];
    end

    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        miss_idx_d  = miss_idx_q;
        miss_tag_d  = miss_tag_q;
        miss_pend_d = miss_pend_q;
        mem_en_d    = mem_en_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        fill_we     = 1'b0;

        // The completion of a missed access is not a first-lookup hit.
        if (req && hit) begin
            if (miss_pend_q)              miss_pend_d = 1'b0;
            else if (hit_cnt_q != '1)     hit_cnt_d   = hit_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    victim_d    = victim_way;
                    miss_idx_d  = p1_idx;
                    miss_tag_d  = p1_tag;
                    miss_pend_d = 1'b1;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    mem_en_d = 1'b1;
                    if (valid_mem[victim_way][p1_idx] && dirty_mem[victim_way][p1_idx]) begin
                        state_d    = S_WB;
                        mem_wr_d   = 1'b1;
                        mem_addr_d = {tag_mem[victim_way][p1_idx], p1_idx, {OFF_W{1'b0}}};
                    end else begin
                        state_d    = S_FILL_REQ;
                        mem_wr_d   = 1'b0;
                        mem_addr_d = {p1_tag, p1_idx, {OFF_W{1'b0}}};
                    end
                end
            end
            S_WB: begin
                if (mem_ack_i) begin
                    state_d    = S_FILL_REQ;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                end
            end
            S_FILL_REQ: begin
                if (mem_ack_i) begin
                    fill_we  = 1'b1;
                    state_d  = S_FILL;
                    mem_en_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            victim_q    <= 1'b0;
            miss_idx_q  <= '0;
            miss_tag_q  <= '0;
            miss_pend_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            miss_idx_q  <= miss_idx_d;
            miss_tag_q  <= miss_tag_d;
            miss_pend_q <= miss_pend_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_mem[0] <= '0;
            valid_mem[1] <= '0;
            dirty_mem[0] <= '0;
            dirty_mem[1] <= '0;
            lru_mem      <= '0;
        end else begin
            if (req && hit) lru_mem[p1_idx] <= ~hit_way;
            if (wr_hit)     dirty_mem[hit_way][p1_idx] <= 1'b1;
            if (fill_we) begin
                valid_mem[victim_q][miss_idx_q] <= 1'b1;
                dirty_mem[victim_q][miss_idx_q] <= 1'b0;
                lru_mem[miss_idx_q]             <= ~victim_q;
            end
        end
    end

    // Line contents carry no reset; valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (wr_hit) data_mem[hit_way][p1_idx][{p1_word, 5'b0} +: 32] <= p1_data_i;
        if (fill_we) begin
            data_mem[victim_q][miss_idx_q] <= mem_data_i;
            tag_mem[victim_q][miss_idx_q]  <= miss_tag_q;
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = data_mem[victim_q][miss_idx_q];
    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign hit_cnt_o    = hit_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;
endmodule

// File: tb/tb_dcache_2way.sv
// tb/tb_dcache_2way.sv - directed self-checking bench for dcache_2way
module tb_dcache_2way;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int SETS   = 32;
    localparam int CNT_W  = 4;
    localparam int LAT    = 3;
    localparam int MAX_ST = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [31:0]       p1_wdata = '0;
    logic              p1_rd = 1'b0;
    logic              p1_wr = 1'b0;
    logic [31:0]       p1_rdata;
    logic              p1_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wline;
    logic              mem_enable;
    logic              mem_write;
    logic [LINE_W-1:0] mem_rline = '0;
    logic              mem_ack = 1'b0;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dcache_2way #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SETS(SETS), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
        .p1_MemRead_i(p1_rd), .p1_MemWrite_i(p1_wr),
        .p1_data_o(p1_rdata), .p1_stall_o(p1_stall),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wline),
        .mem_enable_o(mem_enable), .mem_write_o(mem_write),
        .mem_data_i(mem_rline), .mem_ack_i(mem_ack),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    // Backing memory: unwritten words hold their own byte address.
    logic [LINE_W-1:0] mem [int];
    int                lat_cnt = 0;
    int                wb_cnt = 0;
    int                seamless_cnt = 0;
    int                wr_cycles = 0;
    logic [31:0]       wb_addr = '0;
    logic [LINE_W-1:0] wb_data = '0;

    function automatic logic [LINE_W-1:0] gen_line(input logic [31:0] a);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = a + 32'(w * 4);
        return l;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ack <= 1'b0;
            lat_cnt <= 0;
        end else if (mem_ack) begin
            mem_ack <= 1'b0;
            lat_cnt <= 0;
        end else if (mem_enable) begin
            if (lat_cnt == LAT - 2) begin
                mem_ack <= 1'b1;
                if (mem_write) begin
                    mem[int'(mem_addr >> 5)] = mem_wline;
                    wb_cnt  <= wb_cnt + 1;
                    wb_addr <= mem_addr;
                    wb_data <= mem_wline;
                end else begin
                    mem_rline <= mem.exists(int'(mem_addr >> 5)) ? mem[int'(mem_addr >> 5)] : gen_line(mem_addr);
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    logic prev_wb_ack = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_wb_ack = 1'b0;
        end else begin
            if (prev_wb_ack && mem_enable && !mem_write) seamless_cnt++;
            if (mem_enable && mem_write) wr_cycles++;
            prev_wb_ack = mem_ack && mem_enable && mem_write;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int stalls);
        @(negedge clk);
        p1_addr  = addr;
        p1_wdata = wd;
        p1_rd    = ~wr;
        p1_wr    = wr;
        stalls   = 0;
        #1;
        while (p1_stall && stalls < MAX_ST) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        chk("stall_bound", 64'(stalls < MAX_ST), 64'd1);
        rd = p1_rdata;
        @(posedge clk);
        #1;
        p1_rd = 1'b0;
        p1_wr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        p1_rd = 1'b0;
        p1_wr = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] rd;
    int          st;
    int          wb0, sm0, wc0, n;

    initial begin
        repeat (2) @(negedge clk);
        p1_addr = 32'h404;
        p1_rd   = 1'b1;
        #1;
        chk("rst_mem_enable", 64'(mem_enable), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        chk("rst_rdata", 64'(p1_rdata), 64'd0);
        chk("rst_stall", 64'(p1_stall), 64'd1);
        p1_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Cold read
        wc0 = wr_cycles;
        access(1'b0, 32'h404, 32'h0, rd, st);
        chk("cold_data", 64'(rd), 64'h404);
        chk("cold_stalled", 64'(st > 1), 64'd1);
        chk("cold_miss_cnt", 64'(miss_cnt), 64'd1);
        chk("cold_hit_cnt", 64'(hit_cnt), 64'd0);
        chk("cold_no_write", 64'(wr_cycles - wc0), 64'd0);
        access(1'b0, 32'h404, 32'h0, rd, st);
        chk("rehit_stall", 64'(st), 64'd0);
        chk("rehit_data", 64'(rd), 64'h404);
        chk("rehit_hit_cnt", 64'(hit_cnt), 64'd1);

        // Two-way reuse in set 0
        do_reset();
        wb0 = wb_cnt;
        access(1'b0, 32'h000, 32'h0, rd, st);
        access(1'b0, 32'h400, 32'h0, rd, st);
        access(1'b0, 32'h000, 32'h0, rd, st);
        chk("reuse_a_stall", 64'(st), 64'd0);
        chk("reuse_a_data", 64'(rd), 64'h0);
        access(1'b0, 32'h400, 32'h0, rd, st);
        chk("reuse_b_stall", 64'(st), 64'd0);
        chk("reuse_b_data", 64'(rd), 64'h400);
        access(1'b0, 32'h800, 32'h0, rd, st);
        chk("reuse_c_data", 64'(rd), 64'h800);
        chk("reuse_c_no_wb", 64'(wb_cnt - wb0), 64'd0);
        access(1'b0, 32'h400, 32'h0, rd, st);
        chk("reuse_b_kept", 64'(st), 64'd0);
        access(1'b0, 32'h000, 32'h0, rd, st);
        chk("reuse_a_evicted", 64'(st > 0), 64'd1);
        chk("reuse_miss_cnt", 64'(miss_cnt), 64'd4);
        chk("reuse_hit_cnt", 64'(hit_cnt), 64'd3);

        // Dirty eviction
        do_reset();
        wb0 = wb_cnt;
        sm0 = seamless_cnt;
        access(1'b1, 32'h004, 32'hDEADBEEF, rd, st);
        access(1'b0, 32'h400, 32'h0, rd, st);
        access(1'b0, 32'h800, 32'h0, rd, st);
        chk("dirty_fill_data", 64'(rd), 64'h800);
        chk("dirty_wb_count", 64'(wb_cnt - wb0), 64'd1);
        chk("dirty_wb_addr", 64'(wb_addr), 64'h0);
        chk("dirty_wb_word1", 64'(wb_data[63:32]), 64'hDEADBEEF);
        chk("dirty_wb_word0", 64'(wb_data[31:0]), 64'h0);
        chk("dirty_wb_to_fill", 64'(seamless_cnt - sm0), 64'd1);
        access(1'b0, 32'h004, 32'h0, rd, st);
        chk("dirty_readback", 64'(rd), 64'hDEADBEEF);

        // Write-miss allocate
        do_reset();
        wb0 = wb_cnt;
        access(1'b1, 32'hC0C, 32'h12345678, rd, st);
        chk("wmiss_stalled", 64'(st > 0), 64'd1);
        access(1'b0, 32'hC0C, 32'h0, rd, st);
        chk("wmiss_read_stall", 64'(st), 64'd0);
        chk("wmiss_read_data", 64'(rd), 64'h12345678);
        access(1'b0, 32'h400, 32'h0, rd, st);
        access(1'b0, 32'h800, 32'h0, rd, st);
        chk("wmiss_dirty_wb", 64'(wb_cnt - wb0), 64'd1);
        chk("wmiss_wb_addr", 64'(wb_addr), 64'hC00);
        chk("wmiss_wb_word3", 64'(wb_data[127:96]), 64'h12345678);

        // Counter saturation
        do_reset();
        access(1'b0, 32'h100, 32'h0, rd, st);
        chk("cnt_after_miss_hit", 64'(hit_cnt), 64'd0);
        chk("cnt_after_miss_miss", 64'(miss_cnt), 64'd1);
        for (int i = 0; i < 3; i++) access(1'b0, 32'h100, 32'h0, rd, st);
        chk("cnt_three_hits", 64'(hit_cnt), 64'd3);
        for (int i = 0; i < 17; i++) access(1'b0, 32'h104, 32'h0, rd, st);
        chk("cnt_saturated", 64'(hit_cnt), 64'd15);
        chk("cnt_miss_unchanged", 64'(miss_cnt), 64'd1);

        // Reset while a writeback is outstanding
        do_reset();
        access(1'b1, 32'h004, 32'hA5A5A5A5, rd, st);
        access(1'b0, 32'h400, 32'h0, rd, st);
        access(1'b1, 32'h404, 32'h11111111, rd, st);
        access(1'b0, 32'h004, 32'h0, rd, st);
        chk("rwb_prior_hit", 64'(st), 64'd0);
        chk("rwb_prior_data", 64'(rd), 64'hA5A5A5A5);
        @(negedge clk);
        p1_addr = 32'h800;
        p1_rd   = 1'b1;
        n = 0;
        while (!(mem_enable && mem_write) && n < MAX_ST) begin
            @(negedge clk);
            n++;
        end
        chk("rwb_in_wb", 64'(mem_enable && mem_write), 64'd1);
        rst = 1'b1;
        #1;
        chk("rwb_enable_drop", 64'(mem_enable), 64'd0);
        chk("rwb_write_drop", 64'(mem_write), 64'd0);
        chk("rwb_stall_follows_req", 64'(p1_stall), 64'd1);
        @(negedge clk);
        rst   = 1'b0;
        p1_rd = 1'b0;
        access(1'b0, 32'h004, 32'h0, rd, st);
        chk("rwb_reread_misses", 64'(st > 0), 64'd1);
        chk("rwb_miss_cnt", 64'(miss_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
